dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory (11-bit word address, 32-bit data, synchronous read with 1-cycle latency, write on clock edge) between two requesters.
- Requester 0 is the pipeline memory-access stage; requester 1 is the debug/loader unit.
- Requester 0 has fixed priority, with a starvation guard and a lockable burst mode for requester 1.
- The block sits between both requesters and the memory, and stalls the pipeline when requester 0 is not granted.

Parameters:
- ADDR_W, 11, memory word-address width
- DATA_W, 32, memory data width
- MAX_WAIT, 8, cycles requester 1 may wait ungranted before it is forced ahead of requester 0 (1..255)

Ports:
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  synchronous active-low reset
- req0  in  1  pipeline access request
- we0  in  1  pipeline write enable (1=write, 0=read)
- addr0  in  ADDR_W  pipeline address
- wdata0  in  DATA_W  pipeline write data
- gnt0  out  1  pipeline access accepted this cycle
- stall0  out  1  req0 and not gnt0
- rvalid0  out  1  read data for requester 0 valid
- rdata0  out  DATA_W  read data for requester 0
- req1  in  1  debug access request
- we1  in  1  debug write enable
- addr1  in  ADDR_W  debug address
- wdata1  in  DATA_W  debug write data
- lock1  in  1  debug requests exclusive ownership after its next grant
- gnt1  out  1  debug access accepted this cycle
- rvalid1  out  1  read data for requester 1 valid
- rdata1  out  DATA_W  read data for requester 1
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_write  out  1  memory write strobe
- mem_rdata  in  DATA_W  memory read data (1 cycle after address)

Behaviour:
- Clock port is clock; reset is reset_n, synchronous, active-low.
- Reset:
  - state=PRIO.
  - wait_cnt=0.
  - rvalid0/rvalid1=0.
  - rdata0/rdata1=0.
  - gnt0/gnt1/mem_write forced 0 while reset_n=0.
- Handshake:
  - A requester holds req/we/addr/wdata stable until it sees gnt high.
  - A grant completes exactly one single-cycle access.
- Grants are combinational from state and reqs; at most one grant per cycle.
- mem_addr/mem_wdata come from the granted requester, or from requester 0 when no grant.
- mem_write = gnt0&we0 | gnt1&we1.
- Read latency:
  - A granted read at edge T gives rvalidX=1 and rdataX=mem_rdata during cycle T+1 (mem_rdata is passed through, registered valid).
  - rvalid is a 1-cycle pulse.
  - Writes produce no rvalid.
- States:
  - PRIO:
    - gnt0=req0; gnt1=req1&!req0.
    - wait_cnt increments (saturating at MAX_WAIT) when req1&!gnt1, and clears on gnt1.
    - Go to FORCE when wait_cnt==MAX_WAIT-1 and req1 is still ungranted.
    - Go to LOCK on gnt1&lock1.
  - FORCE:
    - gnt1=req1, gnt0=0.
    - Return to PRIO after gnt1 (or immediately if req1 drops); wait_cnt clears.
    - On gnt1&lock1 go to LOCK.
  - LOCK:
    - gnt1=req1, gnt0=0 every cycle.
    - Go to PRIO when lock1=0 (sampled in the same cycle, any req1 that cycle is still granted); wait_cnt clears.
- Simultaneous req0&req1 in PRIO: requester 0 wins and wait_cnt counts.
- MAX_WAIT bounds requester-1 latency to MAX_WAIT+1 cycles outside LOCK.
- Reset mid-access: the pending rvalid is dropped and no grant is issued in the reset cycle.

Optional Feature:
- DMEM_ARB_STATS_EN defined:
  - Adds outputs stat_gnt0[15:0], stat_gnt1[15:0] and stat_force[15:0].
  - These count gnt0, gnt1 and PRIO->FORCE transitions; they saturate at 16'hFFFF and clear on reset.
- DMEM_ARB_STATS_EN undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Pipeline alone: req0 write addr 0x005 data 0xDEADBEEF, then read 0x005 -> gnt0 both cycles, stall0=0, rvalid0=1 with rdata0=0xDEADBEEF one cycle after the read grant.
- Contention: req0 and req1 high together in PRIO -> gnt0=1, gnt1=0, stall0=0; drop req0 -> gnt1 next cycle.
- Starvation: req0 continuously asserted, req1 read 0x7FF held, MAX_WAIT=8 -> gnt1 exactly once, on the 9th cycle of waiting; stall0=1 in that cycle; gnt0 resumes the following cycle.
- Lock burst: req1 writes 0x010..0x013 with lock1=1, req0 held -> four consecutive gnt1, stall0=1 throughout; lock1=0 on the last write -> gnt0 next cycle.
- Reset mid-read: grant a req1 read, assert reset_n=0 on the next edge -> rvalid1=0, state PRIO, wait_cnt=0; no mem_write while reset_n=0.
- With DMEM_ARB_STATS_EN: run the starvation test -> stat_force=1, stat_gnt1=1; after reset all counters read 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester data-memory arbiter with starvation guard and lockable burst.
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              stall0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_gnt0,
    output logic [15:0]       stat_gnt1,
    output logic [15:0]       stat_force
`endif
);

    typedef enum logic [1:0] {
        ST_PRIO  = 2'd0,
        ST_FORCE = 2'd1,
        ST_LOCK  = 2'd2
    } state_t;

    localparam logic [7:0] LP_MAX    = 8'(MAX_WAIT);
    localparam logic [7:0] LP_MAX_M1 = 8'(MAX_WAIT - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_nxt;
    logic       w_gnt0;
    logic       w_gnt1;
    logic       r_rvalid0;
    logic       r_rvalid1;

    always_comb begin
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        case (r_state)
            ST_PRIO: begin
                w_gnt0 = req0;
                w_gnt1 = req1 & ~req0;
                if (w_gnt1) begin
                    w_wait_nxt = 8'd0;
                    if (lock1) begin
                        w_state_nxt = ST_LOCK;
                    end
                end else if (req1) begin
                    if (r_wait_cnt != LP_MAX) begin
                        w_wait_nxt = r_wait_cnt + 8'd1;
                    end
                    // Forcing one cycle early caps the wait at MAX_WAIT+1 cycles.
                    if (r_wait_cnt >= LP_MAX_M1) begin
                        w_state_nxt = ST_FORCE;
                    end
                end
            end
            ST_FORCE: begin
                w_gnt1     = req1;
                w_wait_nxt = 8'd0;
                w_state_nxt = (req1 & lock1) ? ST_LOCK : ST_PRIO;
            end
            ST_LOCK: begin
                w_gnt1     = req1;
                w_wait_nxt = 8'd0;
                if (!lock1) begin
                    w_state_nxt = ST_PRIO;
                end
            end
            default: begin
                w_state_nxt = ST_PRIO;
                w_wait_nxt  = 8'd0;
            end
        endcase
        // No access may start while reset is asserted.
        if (!reset_n) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state    <= ST_PRIO;
            r_wait_cnt <= 8'd0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_rvalid0  <= w_gnt0 & ~we0;
            r_rvalid1  <= w_gnt1 & ~we1;
        end
    end

    assign gnt0      = w_gnt0;
    assign gnt1      = w_gnt1;
    assign stall0    = req0 & ~w_gnt0;
    assign mem_addr  = w_gnt1 ? addr1 : addr0;
    assign mem_wdata = w_gnt1 ? wdata1 : wdata0;
    assign mem_write = (w_gnt0 & we0) | (w_gnt1 & we1);
    assign rvalid0   = r_rvalid0;
    assign rvalid1   = r_rvalid1;
    assign rdata0    = r_rvalid0 ? mem_rdata : '0;
    assign rdata1    = r_rvalid1 ? mem_rdata : '0;

`ifdef DMEM_ARB_STATS_EN
    logic w_force_entry;
    assign w_force_entry = (r_state == ST_PRIO) && (w_state_nxt == ST_FORCE);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stat_gnt0  <= 16'd0;
            stat_gnt1  <= 16'd0;
            stat_force <= 16'd0;
        end else begin
            if (w_gnt0 && (stat_gnt0 != 16'hFFFF)) begin
                stat_gnt0 <= stat_gnt0 + 16'd1;
            end
            if (w_gnt1 && (stat_gnt1 != 16'hFFFF)) begin
                stat_gnt1 <= stat_gnt1 + 16'd1;
            end
            if (w_force_entry && (stat_force != 16'hFFFF)) begin
                stat_force <= stat_force + 16'd1;
            end
        end
    end
`endif

endmodule
